// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
// Execute-stage ALU with registered result and Zero/Carry flags. Single-cycle
// ops complete on the accept edge; logical shifts run serially, one bit
// position per clock, so no barrel shifter is needed. A start/busy/done
// handshake lets the upstream controller stall during serial shifts.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request strobe, sampled only while busy=0
//   ALUControl  4-bit operation code, sampled with start
//   InA, InB    operands, sampled with start; InB[SHW-1:0] is the shift amount
//   busy        high while a serial shift is in progress
//   done        one-cycle pulse: Out/Zero/Carry are newly valid
//   Out         registered result, held until the next completion
//   Zero        registered flag, Out==0
//   Carry       registered carry / borrow / last-shifted-out bit
// -----------------------------------------------------------------------------
module alu_exec #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [3:0]     OP_ADD = 4'b0000;
    localparam logic [3:0]     OP_SUB = 4'b0001;
    localparam logic [3:0]     OP_AND = 4'b0010;
    localparam logic [3:0]     OP_OR  = 4'b0011;
    localparam logic [3:0]     OP_PAS = 4'b0100;
    localparam logic [3:0]     OP_RAN = 4'b0101;
    localparam logic [3:0]     OP_ROR = 4'b0110;
    localparam logic [3:0]     OP_SLL = 4'b0111;
    localparam logic [3:0]     OP_XOR = 4'b1000;
    localparam logic [3:0]     OP_SRL = 4'b1001;
    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};

    // Single-cycle result: {carry, value}. Shift codes only reach here with
    // n=0, where the result is A unchanged and carry is 0.
    function automatic logic [WIDTH:0] alu_single(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0] res;
        case (op)
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            // The extra top bit of a WIDTH+1 subtraction is the borrow.
            OP_SUB:  res = {1'b0, a} - {1'b0, b};
            OP_AND:  res = {1'b0, a & b};
            OP_OR:   res = {1'b0, a | b};
            OP_PAS:  res = {1'b0, b};
            OP_RAN:  res = {1'b0, {(WIDTH-1){1'b0}}, &a};
            OP_ROR:  res = {1'b0, {(WIDTH-1){1'b0}}, |a};
            OP_SLL:  res = {1'b0, a};
            OP_XOR:  res = {1'b0, a ^ b};
            OP_SRL:  res = {1'b0, a};
            default: res = {1'b0, b};
        endcase
        return res;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [SHW-1:0]   cnt_r;
    logic             dir_left_r;

    logic [WIDTH:0]   single_s;
    logic             is_shift_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             exit_bit_s;

    // Decode the incoming request and evaluate the single-cycle datapath.
    always_comb begin
        single_s   = alu_single(ALUControl, InA, InB);
        is_shift_s = (ALUControl == OP_SLL) || (ALUControl == OP_SRL);
        shamt_s    = InB[SHW-1:0];
    end

    // One-position shift of the accumulator and the bit that leaves it.
    always_comb begin
        acc_next_s = acc_r;
        exit_bit_s = 1'b0;
        if (dir_left_r) begin
            acc_next_s = {acc_r[WIDTH-2:0], 1'b0};
            exit_bit_s = acc_r[WIDTH-1];
        end else begin
            acc_next_s = {1'b0, acc_r[WIDTH-1:1]};
            exit_bit_s = acc_r[0];
        end
    end

    // Control FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            acc_r      <= W_ZERO;
            cnt_r      <= CNT_ZERO;
            dir_left_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            Out        <= W_ZERO;
            Zero       <= 1'b1;
            Carry      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (is_shift_s && (shamt_s != CNT_ZERO)) begin
                            acc_r      <= InA;
                            cnt_r      <= shamt_s;
                            dir_left_r <= (ALUControl == OP_SLL);
                            busy       <= 1'b1;
                            state_r    <= ST_SHIFT;
                        end else begin
                            Out   <= single_s[WIDTH-1:0];
                            Carry <= single_s[WIDTH];
                            Zero  <= (single_s[WIDTH-1:0] == W_ZERO);
                            done  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    // Last step: publish the result; intermediate values stay hidden.
                    if (cnt_r == CNT_ONE) begin
                        Out     <= acc_next_s;
                        Carry   <= exit_bit_s;
                        Zero    <= (acc_next_s == W_ZERO);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
